// File: rtl/delay_sa.sv
// delay_sa: per-channel delayed sample fetch for one focal point.
// On an accepted start the block clears the downstream accumulator, then
// streams one delayed sample per channel, in ascending channel order, from
// mem[c][(focal_idx + delay[c]) mod DEPTH], and finally pulses done_channel.
module delay_sa #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int DEPTH        = 64,
    localparam int CH_W        = $clog2(NUM_CHANNELS),
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [CH_W-1:0]       wr_channel,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  dly_wr_en,
    input  logic [CH_W-1:0]       dly_channel,
    input  logic [ADDR_W-1:0]     dly_value,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     focal_idx,
    output logic                  busy,
    output logic                  start_sum,
    output logic                  sum_en,
    output logic [DATA_WIDTH-1:0] delayed_sample,
    output logic                  done_channel
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

    // Sample storage and per-channel delay table
    logic [DATA_WIDTH-1:0] mem [NUM_CHANNELS][DEPTH];
    logic [ADDR_W-1:0]     dly_q [NUM_CHANNELS];
    logic [ADDR_W-1:0]     dly_d [NUM_CHANNELS];

    state_t                state_q, state_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [ADDR_W-1:0]     focal_q, focal_d;
    logic                  busy_q, busy_d;
    logic                  start_sum_q, start_sum_d;
    logic                  sum_en_q, sum_en_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [ADDR_W-1:0]     rd_addr;
    logic                  idle;

    assign idle = (state_q == S_IDLE);

    // Read address wraps naturally in ADDR_W bits (DEPTH is a power of two)
    assign rd_addr = focal_q + dly_q[ch_q];

    // Next-state, delay-table update and registered-output decode
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        ch_d        = ch_q;
        focal_d     = focal_q;
        dly_d       = dly_q;

        if (dly_wr_en && idle) begin
            dly_d[dly_channel] = dly_value;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    focal_d = focal_idx;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                ch_d    = '0;
                state_d = S_READ;
            end
            S_READ: begin
                ch_d = ch_q + CH_W'(1);
                if (ch_q == LAST_CH) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they are aligned with it
        start_sum_d = (state_d == S_CLEAR);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        // Read issued in READ appears one cycle later; zero when not qualified
        sum_en_d    = (state_q == S_READ);
        rd_data_d   = (state_q == S_READ) ? mem[ch_q][rd_addr] : '0;
    end

    // FSM, control and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            focal_q     <= '0;
            dly_q       <= '{default: '0};
            busy_q      <= 1'b0;
            start_sum_q <= 1'b0;
            sum_en_q    <= 1'b0;
            done_q      <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q     <= state_d;
            ch_q        <= ch_d;
            focal_q     <= focal_d;
            dly_q       <= dly_d;
            busy_q      <= busy_d;
            start_sum_q <= start_sum_d;
            sum_en_q    <= sum_en_d;
            done_q      <= done_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Sample memory write port, accepted only while idle
    always_ff @(posedge clk) begin
        // NOTE: the sample memory is deliberately not reset; its contents survive a reset.
        if (wr_en && idle) begin
            mem[wr_channel][wr_addr] <= wr_data;
        end
    end

    assign busy           = busy_q;
    assign start_sum      = start_sum_q;
    assign sum_en         = sum_en_q;
    assign delayed_sample = rd_data_q;
    assign done_channel   = done_q;

endmodule

// File: tb/tb_delay_sa.sv
// tb_delay_sa: directed, table-driven bench for delay_sa (default parameters).
// Memory is filled with mem[c][a] = 100*c + a; each frame's outputs are
// recorded per cycle relative to the accepting edge and compared to
// hand-computed expectations.
module tb_delay_sa;

    localparam int DW = 16;
    localparam int NC = 4;
    localparam int DP = 64;
    localparam int CW = 2;
    localparam int AW = 6;
    localparam int NREC = 20;

    typedef logic [DW-1:0] samp4_t [NC];
    typedef logic [AW-1:0] dly4_t  [NC];

    typedef struct {
        logic [AW-1:0] focal;
        dly4_t         dly;
        samp4_t        exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [CW-1:0] wr_channel;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          dly_wr_en;
    logic [CW-1:0] dly_channel;
    logic [AW-1:0] dly_value;
    logic          start;
    logic [AW-1:0] focal_idx;
    logic          busy;
    logic          start_sum;
    logic          sum_en;
    logic [DW-1:0] delayed_sample;
    logic          done_channel;

    int total = 0;
    int bad   = 0;

    // Per-cycle record of one frame; index i = cycles after the accepting edge
    logic          tr_ss   [NREC+1];
    logic          tr_se   [NREC+1];
    logic          tr_dc   [NREC+1];
    logic          tr_busy [NREC+1];
    logic [DW-1:0] tr_ds   [NREC+1];

    vec_t vec [4];

    delay_sa #(
        .DATA_WIDTH  (DW),
        .NUM_CHANNELS(NC),
        .DEPTH       (DP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_channel    (wr_channel),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .dly_wr_en     (dly_wr_en),
        .dly_channel   (dly_channel),
        .dly_value     (dly_value),
        .start         (start),
        .focal_idx     (focal_idx),
        .busy          (busy),
        .start_sum     (start_sum),
        .sum_en        (sum_en),
        .delayed_sample(delayed_sample),
        .done_channel  (done_channel)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic write_mem(input int c, input int a, input logic [DW-1:0] d);
        @(negedge clk);
        wr_en      = 1'b1;
        wr_channel = CW'(c);
        wr_addr    = AW'(a);
        wr_data    = d;
        @(negedge clk);
        wr_en      = 1'b0;
    endtask

    task automatic set_delays(input dly4_t d);
        for (int c = 0; c < NC; c++) begin
            @(negedge clk);
            dly_wr_en   = 1'b1;
            dly_channel = CW'(c);
            dly_value   = d[c];
        end
        @(negedge clk);
        dly_wr_en = 1'b0;
    endtask

    // Pulse start with focal f, then record NREC cycles; optional injections
    // (cycle index 0 = none): a second start, a delay write, a reset pulse.
    task automatic run_frame(input logic [AW-1:0] f, input int inj_start,
                             input logic [AW-1:0] inj_focal, input int inj_dly,
                             input int inj_rst);
        @(negedge clk);
        start     = 1'b1;
        focal_idx = f;
        for (int i = 1; i <= NREC; i++) begin
            @(negedge clk);
            start     = 1'b0;
            dly_wr_en = 1'b0;
            reset     = 1'b1;
            tr_ss[i]   = start_sum;
            tr_se[i]   = sum_en;
            tr_dc[i]   = done_channel;
            tr_busy[i] = busy;
            tr_ds[i]   = delayed_sample;
            if (i == inj_start) begin
                start     = 1'b1;
                focal_idx = inj_focal;
            end
            if (i == inj_dly) begin
                dly_wr_en   = 1'b1;
                dly_channel = '0;
                dly_value   = AW'(33);
            end
            if (i == inj_rst) reset = 1'b0;
        end
    endtask

    // Compare recorded cycles lo..hi against a frame accepted at record index base
    task automatic check_timing(input string nm, input samp4_t e, input int base,
                                input int lo, input int hi);
        int j;
        logic          x_ss, x_se, x_dc, x_busy;
        logic [DW-1:0] x_ds;
        for (int i = lo; i <= hi; i++) begin
            j      = i - base;
            x_ss   = (j == 1);
            x_se   = (j >= 3) && (j <= 2 + NC);
            x_dc   = (j == 3 + NC);
            x_busy = (j >= 1) && (j <= 3 + NC);
            x_ds   = x_se ? e[j-3] : '0;
            check($sformatf("%s c%0d start_sum", nm, i), 32'(tr_ss[i]), 32'(x_ss));
            check($sformatf("%s c%0d sum_en", nm, i), 32'(tr_se[i]), 32'(x_se));
            check($sformatf("%s c%0d done", nm, i), 32'(tr_dc[i]), 32'(x_dc));
            check($sformatf("%s c%0d busy", nm, i), 32'(tr_busy[i]), 32'(x_busy));
            check($sformatf("%s c%0d sample", nm, i), 32'(tr_ds[i]), 32'(x_ds));
        end
    endtask

    initial begin
        reset       = 1'b0;
        wr_en       = 1'b0;
        wr_channel  = '0;
        wr_addr     = '0;
        wr_data     = '0;
        dly_wr_en   = 1'b0;
        dly_channel = '0;
        dly_value   = '0;
        start       = 1'b0;
        focal_idx   = '0;

        // Vector table: focal, delays, expected samples per channel
        vec[0] = '{focal: 6'd10, dly: '{6'd0,  6'd1,  6'd2,  6'd3},
                   exp: '{16'd10, 16'd111, 16'd212, 16'd313}};
        vec[1] = '{focal: 6'd62, dly: '{6'd0,  6'd1,  6'd3,  6'd2},
                   exp: '{16'd62, 16'd163, 16'd201, 16'd300}};
        vec[2] = '{focal: 6'd0,  dly: '{6'd63, 6'd0,  6'd5,  6'd40},
                   exp: '{16'd63, 16'd100, 16'd205, 16'd340}};
        vec[3] = '{focal: 6'd33, dly: '{6'd31, 6'd32, 6'd30, 6'd0},
                   exp: '{16'd0,  16'd101, 16'd263, 16'd333}};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst busy", 32'(busy), 0);
        check("rst start_sum", 32'(start_sum), 0);
        check("rst sum_en", 32'(sum_en), 0);
        check("rst done", 32'(done_channel), 0);
        check("rst sample", 32'(delayed_sample), 0);
        reset = 1'b1;

        // Fill memory: mem[c][a] = 100*c + a
        for (int c = 0; c < NC; c++) begin
            for (int a = 0; a < DP; a++) begin
                @(negedge clk);
                wr_en      = 1'b1;
                wr_channel = CW'(c);
                wr_addr    = AW'(a);
                wr_data    = DW'(100 * c + a);
            end
        end
        @(negedge clk);
        wr_en = 1'b0;

        // Table-driven frames: basic, wrap, full-range delays, carry dropped
        for (int v = 0; v < 4; v++) begin
            set_delays(vec[v].dly);
            run_frame(vec[v].focal, 0, '0, 0, 0);
            check_timing($sformatf("vec%0d", v), vec[v].exp, 0, 1, NREC);
        end

        // start during READ and delay write during DRAIN are ignored
        set_delays(vec[0].dly);
        run_frame(6'd10, 3, 6'd20, 2 + NC, 0);
        check_timing("busy_ign", vec[0].exp, 0, 1, NREC);
        run_frame(6'd10, 0, '0, 0, 0);
        check_timing("busy_ign_after", vec[0].exp, 0, 1, NREC);

        // Back-to-back: start on the first idle cycle after DONE
        run_frame(6'd10, 4 + NC, 6'd20, 0, 0);
        check_timing("b2b_first", vec[0].exp, 0, 1, 4 + NC);
        check_timing("b2b_second", '{16'd20, 16'd121, 16'd222, 16'd323}, 4 + NC, 5 + NC, NREC);

        // Reset in the second READ cycle: frame aborted, delay table cleared
        run_frame(6'd10, 0, '0, 0, 3);
        check_timing("rst_mid_pre", vec[0].exp, 0, 1, 3);
        check_timing("rst_mid_post", vec[0].exp, -100, 4, NREC);
        run_frame(6'd10, 0, '0, 0, 0);
        check_timing("rst_mid_zero_dly", '{16'd10, 16'd110, 16'd210, 16'd310}, 0, 1, NREC);

        // Extreme sample values pass unmodified
        write_mem(1, 7, 16'hFFFF);
        write_mem(2, 8, 16'h8000);
        set_delays('{6'd0, 6'd0, 6'd1, 6'd2});
        run_frame(6'd7, 0, '0, 0, 0);
        check_timing("extreme", '{16'd7, 16'hFFFF, 16'h8000, 16'd309}, 0, 1, NREC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
